// File: rtl/iq_mag_sched.sv
// Round-robin scheduler sharing one I^2+Q^2 pipeline among NUM_CH requesters,
// with a channel-tag delay line and a credit-protected FWFT result FIFO.
// Optional IQ_SCHED_ERR_EN: sticky tag/result misalignment flag on err.
module iq_mag_sched #(
    parameter int IQ_DATA_WIDTH = 32,
    parameter int NUM_CH        = 4,
    parameter int PIPE_LATENCY  = 6,
    parameter int FIFO_DEPTH    = 8,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CH-1:0]               req_val,
    output logic [NUM_CH-1:0]               req_rdy,
    input  logic [NUM_CH*IQ_DATA_WIDTH-1:0] req_i,
    input  logic [NUM_CH*IQ_DATA_WIDTH-1:0] req_q,
    output logic                            pipe_val,
    output logic [IQ_DATA_WIDTH-1:0]        pipe_i,
    output logic [IQ_DATA_WIDTH-1:0]        pipe_q,
    input  logic [IQ_DATA_WIDTH-1:0]        pipe_result,
    input  logic                            pipe_result_val,
    output logic [IQ_DATA_WIDTH-1:0]        result,
    output logic [CH_W-1:0]                 result_ch,
    output logic                            result_val,
    input  logic                            result_rdy,
    output logic                            err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CH_W:0]   NUM_CH_C = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W:0]  DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);

    logic [CH_W-1:0]          ptr_reg;
    logic [CH_W-1:0]          win;
    logic [CH_W:0]            cand;
    logic                     any_req;
    logic                     has_credit;
    logic                     handshake;
    logic                     push;
    logic                     pop;
    logic [CNT_W:0]           used;

    logic                     pipe_val_reg;
    logic [IQ_DATA_WIDTH-1:0] pipe_i_reg;
    logic [IQ_DATA_WIDTH-1:0] pipe_q_reg;
    logic [CH_W-1:0]          pipe_ch_reg;
    logic [CNT_W-1:0]         inflight_reg;

    logic                     tag_val [PIPE_LATENCY];
    logic [CH_W-1:0]          tag_ch  [PIPE_LATENCY];

    logic [IQ_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [CH_W-1:0]          mem_ch   [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         rd_ptr_reg;
    logic [CNT_W-1:0]         count_reg;

    // Credit covers both samples still in the pipe and entries already queued,
    // so a result always has a FIFO slot when it pops out of the pipeline.
    assign used       = {1'b0, inflight_reg} + {1'b0, count_reg};
    assign has_credit = (used < DEPTH_C);

    always_comb begin
        any_req = 1'b0;
        win     = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, ptr_reg} + (CH_W+1)'(i);
            if (cand >= NUM_CH_C) begin
                cand = cand - NUM_CH_C;
            end
            if (!any_req && req_val[cand[CH_W-1:0]]) begin
                any_req = 1'b1;
                win     = cand[CH_W-1:0];
            end
        end
    end

    assign handshake = any_req & has_credit;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rdy
        assign req_rdy[gi] = handshake && (win == CH_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            pipe_val_reg <= 1'b0;
            pipe_i_reg   <= '0;
            pipe_q_reg   <= '0;
            pipe_ch_reg  <= '0;
            inflight_reg <= '0;
        end else begin
            pipe_val_reg <= handshake;
            if (handshake) begin
                ptr_reg     <= (win == LAST_CH) ? '0 : win + 1'b1;
                pipe_i_reg  <= req_i[win*IQ_DATA_WIDTH +: IQ_DATA_WIDTH];
                pipe_q_reg  <= req_q[win*IQ_DATA_WIDTH +: IQ_DATA_WIDTH];
                pipe_ch_reg <= win;
            end
            // Counted at the grant so the registered issue stage is never unprotected.
            case ({handshake, push})
                2'b10:   inflight_reg <= inflight_reg + 1'b1;
                2'b01:   inflight_reg <= inflight_reg - 1'b1;
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    assign pipe_val = pipe_val_reg;
    assign pipe_i   = pipe_i_reg;
    assign pipe_q   = pipe_q_reg;

    for (genvar gi = 0; gi < PIPE_LATENCY; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_val[gi] <= 1'b0;
                    tag_ch[gi]  <= '0;
                end else begin
                    tag_val[gi] <= pipe_val_reg;
                    tag_ch[gi]  <= pipe_ch_reg;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_val[gi] <= 1'b0;
                    tag_ch[gi]  <= '0;
                end else begin
                    tag_val[gi] <= tag_val[gi-1];
                    tag_ch[gi]  <= tag_ch[gi-1];
                end
            end
        end
    end

`ifdef IQ_SCHED_ERR_EN
    logic err_reg;

    assign push = pipe_result_val & tag_val[PIPE_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (pipe_result_val != tag_val[PIPE_LATENCY-1]) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign push = pipe_result_val;
    assign err  = 1'b0;
`endif

    assign result_val = (count_reg != '0);
    assign pop        = result_val & result_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_reg] <= pipe_result;
            mem_ch[wr_ptr_reg]   <= tag_ch[PIPE_LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Fall-through head: the entry is visible as soon as count is non-zero.
    assign result    = mem_data[rd_ptr_reg];
    assign result_ch = mem_ch[rd_ptr_reg];

endmodule
